d_flip_flop: RTL and testbench

//   Positive-edge-triggered D flip-flop with complementary outputs Q and QB.

---
 rtl/d_flip_flop_pkg.sv | 10 +
 rtl/d_flip_flop_dff_bit.sv | 23 ++
 rtl/d_flip_flop.sv | 33 +++
 tb/tb_d_flip_flop.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/d_flip_flop_pkg.sv
// Shared constants for the d_flip_flop storage primitive.
// Latency: n/a (declarations only).
// Backpressure: n/a (no flow control on a plain register).
`timescale 1ns/1ps
package d_flip_flop_pkg;

    // Default lane count: a single flip-flop.
    localparam int DFF_DEFAULT_WIDTH = 1;

endpackage : d_flip_flop_pkg

// File: rtl/d_flip_flop_dff_bit.sv
// One-bit edge-triggered storage cell with asynchronous active-high reset.
// Latency: one rising CLK edge from D to Q; reset takes effect immediately.
// Backpressure: none; D is sampled on every rising edge while RST is low.
`timescale 1ns/1ps
module dff_bit #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic CLK,
    input  logic RST,
    input  logic D,
    output logic Q
);

    // Reset forces the cell to RST_VAL regardless of CLK; otherwise capture D on rising edges.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            Q <= RST_VAL;
        end else begin
            Q <= D;
        end
    end

endmodule : dff_bit

// File: rtl/d_flip_flop.sv
// WIDTH parallel D flip-flops with complementary outputs Q and QB.
// Latency: one rising CLK edge from D to Q/QB; RST clears to RST_VAL at once.
// Backpressure: none; every rising edge with RST low overwrites the stored value.
`timescale 1ns/1ps
module d_flip_flop
    import d_flip_flop_pkg::*;
#(
    parameter int               WIDTH   = DFF_DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] QB
);

    // One independent cell per lane, all sharing CLK and RST.
    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        dff_bit #(
            .RST_VAL (RST_VAL[i])
        ) u_cell (
            .CLK (CLK),
            .RST (RST),
            .D   (D[i]),
            .Q   (Q[i])
        );
    end

    // QB is derived from the same state so the two outputs can never disagree.
    assign QB = ~Q;

endmodule : d_flip_flop

// File: tb/tb_d_flip_flop.sv
// Directed bench for d_flip_flop: a WIDTH=1 default instance and a WIDTH=4, RST_VAL=4'hA instance.
// Clock starts high at 0 ns, period 20 ns, rising edges at 20, 40, 60, ...
// A history-based model predicts Q at every falling edge; literal checks pin the model.
`timescale 1ns/1ps
module tb_d_flip_flop;

    logic       clk;
    logic       rst;
    logic [0:0] d;
    logic [0:0] q;
    logic [0:0] qb;
    logic       rst4;
    logic [3:0] d4;
    logic [3:0] q4;
    logic [3:0] qb4;

    int checks = 0;
    int errors = 0;
    bit done   = 1'b0;
    int rst_pulses  = 0;
    int rst4_pulses = 0;

    d_flip_flop u_dut1 (
        .CLK (clk),
        .RST (rst),
        .D   (d),
        .Q   (q),
        .QB  (qb)
    );

    d_flip_flop #(
        .WIDTH   (4),
        .RST_VAL (4'hA)
    ) u_dut4 (
        .CLK (clk),
        .RST (rst4),
        .D   (d4),
        .Q   (q4),
        .QB  (qb4)
    );

    initial begin
        clk = 1'b1;
        forever #10 clk = ~clk;
    end

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic at(input int t);
        #(t - int'($time));
    endtask

    // Count reset assertions so the model sees pulses that fall between samples.
    always @(posedge rst)  rst_pulses++;
    always @(posedge rst4) rst4_pulses++;

    // Model: Q at mid-cycle is RST_VAL if reset is high now or was asserted since the
    // last rising edge; otherwise the D seen at that edge if reset was low there;
    // otherwise the previous value persists.
    initial begin
        logic [0:0] exp1;
        logic [3:0] exp4;
        logic [0:0] cap_d1;
        logic [3:0] cap_d4;
        bit         cap_ok1;
        bit         cap_ok4;
        int         p1;
        int         p4;
        exp1 = 1'b0;
        exp4 = 4'hA;
        forever begin
            @(posedge clk);
            cap_d1  = d;
            cap_ok1 = !rst;
            p1      = rst_pulses;
            cap_d4  = d4;
            cap_ok4 = !rst4;
            p4      = rst4_pulses;
            @(negedge clk);
            if (rst || rst_pulses != p1) exp1 = 1'b0;
            else if (cap_ok1)            exp1 = cap_d1;
            if (rst4 || rst4_pulses != p4) exp4 = 4'hA;
            else if (cap_ok4)              exp4 = cap_d4;
            check("model_q1",  {3'b0, q},  {3'b0, exp1});
            check("model_qb1", {3'b0, qb}, {3'b0, ~exp1});
            check("model_q4",  q4,  exp4);
            check("model_qb4", qb4, ~exp4);
        end
    end

    // QB must be the complement of Q at every sampled instant after the first reset.
    initial begin
        #1.5;
        while (!done) begin
            check("inv_qb1", {3'b0, qb}, {3'b0, ~q});
            check("inv_qb4", qb4, ~q4);
            #1;
        end
    end

    // Directed stimulus with hand-computed expectations.
    initial begin
        rst  = 1'b1;
        d    = 1'b1;
        rst4 = 1'b1;
        d4   = 4'h3;

        // Reset held across edges at 20 and 40 with D=1.
        at(5);   check("rst_q1", {3'b0, q}, 4'h0); check("rst_qb1", {3'b0, qb}, 4'h1);
                 check("rst_q4", q4, 4'hA);        check("rst_qb4", qb4, 4'h5);
        at(25);  check("rst_edge20_q1", {3'b0, q}, 4'h0);
        at(45);  check("rst_edge40_q1", {3'b0, q}, 4'h0);
        at(47);  rst = 1'b0; rst4 = 1'b0;
        at(55);  check("release_hold_q1", {3'b0, q}, 4'h0); check("release_hold_q4", q4, 4'hA);
        at(65);  check("first_capture_q1", {3'b0, q}, 4'h1);
                 check("cap_q4", q4, 4'h3); check("cap_qb4", qb4, 4'hC);

        // Capture sequence relative to base 100 (a rising edge); D=0 before it.
        at(95);  d = 1'b0;
        at(105); check("base_q1", {3'b0, q}, 4'h0);
        at(107); d = 1'b1;
        at(115); d = 1'b0;
        at(116); check("glitch1_q1", {3'b0, q}, 4'h0);
        at(125); check("edge120_q1", {3'b0, q}, 4'h0);
        at(130); d4 = 4'h5;
        at(132); d = 1'b1;
        at(142); d = 1'b0;
        at(145); check("edge140_q1", {3'b0, q}, 4'h1); check("edge140_q4", q4, 4'h5);
        at(152); d = 1'b1;
        at(153); check("glitch2a_q1", {3'b0, q}, 4'h1);
        at(155); d = 1'b0;
        at(156); check("glitch2b_q1", {3'b0, q}, 4'h1);
        at(165); check("edge160_q1", {3'b0, q}, 4'h0); check("edge160_qb1", {3'b0, qb}, 4'h1);
        at(167); d = 1'b1;
        at(183); check("edge180_q1", {3'b0, q}, 4'h1);

        // Asynchronous reset mid-hold, then held across the edge at 200 with D=1.
        at(185); rst = 1'b1; rst4 = 1'b1;
        at(186); check("async_q1", {3'b0, q}, 4'h0); check("async_qb1", {3'b0, qb}, 4'h1);
                 check("async_q4", q4, 4'hA);
        at(205); check("rst_edge200_q1", {3'b0, q}, 4'h0);
        at(213); rst = 1'b0; rst4 = 1'b0;
        at(215); check("release2_q1", {3'b0, q}, 4'h0);
        at(225); check("edge220_q1", {3'b0, q}, 4'h1); check("edge220_qb1", {3'b0, qb}, 4'h0);
                 check("edge220_q4", q4, 4'h5);
        at(240);
        done = 1'b1;
        #2;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_d_flip_flop
